// File: rtl/mux5to1_pkg.sv
// Shared select-code definitions for the write-back result mux.
package mux5to1_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_ALU = 3'd0;
  localparam sel_t SEL_MEM = 3'd1;
  localparam sel_t SEL_PC4 = 3'd2;
  localparam sel_t SEL_PCT = 3'd3;
  localparam sel_t SEL_IMM = 3'd4;

  // Codes in this range select nothing and flag an error.
  localparam sel_t SEL_ILL_MIN = 3'd5;
  localparam sel_t SEL_ILL_MAX = 3'd7;

  localparam int unsigned NUM_SRC = 5;

endpackage

// File: rtl/mux5to1_sel_decode.sv
// Decodes the 3-bit select into a one-hot source enable and an illegal-code flag.
module mux5to1_sel_decode
  import mux5to1_pkg::*;
(
  input  sel_t                 sel,
  output logic [NUM_SRC-1:0]   en,
  output logic                 illegal
);

  always_comb begin
    en      = '0;
    illegal = 1'b0;
    unique case (sel)
      SEL_ALU: en[SEL_ALU] = 1'b1;
      SEL_MEM: en[SEL_MEM] = 1'b1;
      SEL_PC4: en[SEL_PC4] = 1'b1;
      SEL_PCT: en[SEL_PCT] = 1'b1;
      SEL_IMM: en[SEL_IMM] = 1'b1;
      3'd5, 3'd6, SEL_ILL_MAX: illegal = 1'b1;
      // Unknown select propagates as X instead of aliasing onto a legal source.
      default: begin
        en      = 'x;
        illegal = 1'bx;
      end
    endcase
  end

endmodule

// File: rtl/mux5to1.sv
// Five-input write-back mux with illegal-select detection and a sticky error flag.
// Define MUX5TO1_REG_OUT_EN to register o_mux; otherwise o_mux is combinational.
module mux5to1
  import mux5to1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [2:0]            i_control_signal,
  input  logic [DATA_WIDTH-1:0] i_mux_0,
  input  logic [DATA_WIDTH-1:0] i_mux_1,
  input  logic [DATA_WIDTH-1:0] i_mux_2,
  input  logic [DATA_WIDTH-1:0] i_mux_3,
  input  logic [DATA_WIDTH-1:0] i_mux_4,
  input  logic                  i_err_clr,
  output logic [DATA_WIDTH-1:0] o_mux,
  output logic                  o_sel_err,
  output logic                  o_sel_err_sticky
);

  logic [NUM_SRC-1:0]    en;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] mux_comb;
  logic                  sticky_q;

  mux5to1_sel_decode u_sel_decode (
    .sel     (i_control_signal),
    .en      (en),
    .illegal (illegal)
  );

  // Illegal codes leave every enable low, so the AND-OR yields zero.
  assign mux_comb = ({DATA_WIDTH{en[SEL_ALU]}} & i_mux_0)
                  | ({DATA_WIDTH{en[SEL_MEM]}} & i_mux_1)
                  | ({DATA_WIDTH{en[SEL_PC4]}} & i_mux_2)
                  | ({DATA_WIDTH{en[SEL_PCT]}} & i_mux_3)
                  | ({DATA_WIDTH{en[SEL_IMM]}} & i_mux_4);

  assign o_sel_err = illegal;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sticky_q <= 1'b0;
    end else if (i_err_clr) begin
      sticky_q <= 1'b0;
    end else if (illegal) begin
      sticky_q <= 1'b1;
    end
  end

  assign o_sel_err_sticky = sticky_q;

`ifdef MUX5TO1_REG_OUT_EN
  logic [DATA_WIDTH-1:0] mux_q;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      mux_q <= '0;
    end else begin
      mux_q <= mux_comb;
    end
  end

  assign o_mux = mux_q;
`else
  assign o_mux = mux_comb;
`endif

endmodule

// File: tb/tb_mux5to1.sv
// Directed scoreboard bench for mux5to1; adapts o_mux timing to MUX5TO1_REG_OUT_EN.
module tb_mux5to1;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         arst;
  logic [2:0]   ctrl;
  logic [W-1:0] d [5];
  logic         clr;
  logic [W-1:0] o_mux;
  logic         o_sel_err;
  logic         o_sticky;

  int           checks = 0;
  int           errors = 0;
  logic         model_sticky = 1'b0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  mux5to1 #(.DATA_WIDTH(W)) dut (
    .i_clk            (clk),
    .i_arst           (arst),
    .i_control_signal (ctrl),
    .i_mux_0          (d[0]),
    .i_mux_1          (d[1]),
    .i_mux_2          (d[2]),
    .i_mux_3          (d[3]),
    .i_mux_4          (d[4]),
    .i_err_clr        (clr),
    .o_mux            (o_mux),
    .o_sel_err        (o_sel_err),
    .o_sel_err_sticky (o_sticky)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, o_mux, e);
    end
  endtask

  // Drive one select for one cycle; checks comb outputs, then sticky after the edge.
  task automatic step(input logic [2:0] sel, input logic clear, input string tag);
    logic [W-1:0] e;
    logic         ill;
    @(negedge clk);
    ctrl = sel;
    clr  = clear;
    ill  = (sel >= 3'd5);
    e    = ill ? '0 : d[sel];
    exp_q.push_back(e);
    #1;
    chk({tag, "_err"}, W'(o_sel_err), W'(ill));
`ifndef MUX5TO1_REG_OUT_EN
    pop_chk({tag, "_mux"});
`endif
    @(posedge clk);
    #1;
    if (clear) model_sticky = 1'b0;
    else if (ill) model_sticky = 1'b1;
    chk({tag, "_sticky"}, W'(o_sticky), W'(model_sticky));
`ifdef MUX5TO1_REG_OUT_EN
    pop_chk({tag, "_mux"});
`endif
    clr = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    ctrl = 3'd0;
    clr  = 1'b0;
    d[0] = 64'h11; d[1] = 64'h22; d[2] = 64'h33; d[3] = 64'h44; d[4] = 64'h55;
    #3;
    chk("reset_sticky", W'(o_sticky), '0);
`ifdef MUX5TO1_REG_OUT_EN
    chk("reset_mux", o_mux, '0);
`endif
    @(negedge clk);
    arst = 1'b0;

    // Legal selects in turn.
    step(3'd0, 1'b0, "sel0");
    step(3'd1, 1'b0, "sel1");
    step(3'd2, 1'b0, "sel2");
    step(3'd3, 1'b0, "sel3");
    step(3'd4, 1'b0, "sel4");

    // Illegal selects set the sticky flag.
    step(3'd5, 1'b0, "sel5");
    step(3'd7, 1'b0, "sel7");
    step(3'd2, 1'b0, "hold");
    step(3'd2, 1'b1, "clear");

    // Async reset between edges clears sticky at once.
    step(3'd6, 1'b0, "sel6");
    @(negedge clk);
    ctrl = 3'd0;
    #2 arst = 1'b1;
    #1;
    model_sticky = 1'b0;
    chk("arst_sticky", W'(o_sticky), '0);
`ifdef MUX5TO1_REG_OUT_EN
    chk("arst_mux", o_mux, '0);
`endif
    arst = 1'b0;

    // Clear wins over a simultaneous illegal select.
    step(3'd5, 1'b0, "set_again");
    step(3'd6, 1'b1, "clr_wins");

    d[3] = 64'hDEADBEEF;
    step(3'd3, 1'b0, "deadbeef");

    // Full-width random data across all selects.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 5; k++) d[k] = {$urandom(), $urandom()};
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
    end

    chk("scoreboard_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
